rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Shares one WIDTH-bit 4:1 mux datapath between four valid/ready requesters.
- A round-robin arbiter drives the mux select. The chosen word goes into a single registered output stage with a valid/ready handshake.
- An optional burst allowance lets a requester keep priority for up to MAX_BURST consecutive transfers.
- Sits between four producer streams and one shared consumer port.

Parameters:
- WIDTH, 4, data width of each requester and of the output.
- MAX_BURST, 1, max consecutive accepted transfers one requester may take before priority rotates. Must be >= 1; 1 means pure round robin.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data0..in_data3  input  WIDTH each  requester data words.
- in_ready  output  4  per-requester ready, combinational.
- out_valid  output  1  output word valid, registered.
- out_data  output  WIDTH  selected word, registered.
- out_sel  output  2  index of the requester whose word is in out_data, registered.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - out_valid=0, out_data=0, out_sel=0.
  - Internal priority pointer ptr=0, last grantee=0, burst count cnt=0.
  - in_ready forced to 4'b0000 while rst_n is low.
- Load condition: load = !out_valid || out_ready. This is a one-deep pipeline with full throughput of one transfer per cycle.
- Grant (combinational):
  - When load=1, search in_valid starting at ptr and going upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3). The first set bit is g.
  - in_ready is one-hot at g. All in_ready bits are 0 if load=0 or no in_valid bit is set.
  - in_ready depends combinationally on out_ready; this path is intended.
- Accept (at the clock edge when load=1 and some in_valid is set):
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - cnt_new = (g==last && cnt!=0) ? cnt+1 : 1; cnt <= cnt_new; last <= g.
  - ptr <= (cnt_new < MAX_BURST) ? g : (g+1) mod 4.
  - With MAX_BURST=1, ptr always moves to g+1.
- Idle (load=1, in_valid=0): out_valid <= 0, cnt <= 0. ptr, last, out_data and out_sel keep their values.
- Stall (out_valid=1, out_ready=0):
  - out_valid, out_data and out_sel hold stable.
  - in_ready=0000; ptr, cnt and last are unchanged.
- Upstream rule: a requester keeps in_valid and its data stable until it sees in_ready. The arbiter does not lock a choice across stall cycles; the grant is re-evaluated on every load cycle.
- Wrap-around: ptr and the search index are 2-bit and wrap from 3 to 0. cnt saturates at MAX_BURST.
- Reset mid-transfer: the pending output word is dropped (out_valid=0 immediately). After release, the first grant goes to the lowest-index valid requester.
- X in the data of an unselected requester must not propagate to out_data.

Test Plan:
1. All in_valid=1111, data0..3 = a,b,c,d, out_ready=1 held, MAX_BURST=1 -> out_sel 0,1,2,3,0,1 on consecutive cycles; out_data a,b,c,d,a,b; in_ready 0001,0010,0100,1000,...
2. Same stimulus; out_ready=0 for 3 cycles while out_data=b -> out_data=b, out_sel=1, out_valid=1 stable, in_ready=0000. After out_ready=1 the next word is c (sel 2); no word is lost or duplicated.
3. Only in_valid[2]=1 with data 7, out_ready=1 -> every cycle out_data=7, out_sel=2, in_ready=0100. Then in_valid[1] also rises with data 3 -> the next grant is requester 1 (search 3,0,1), then 2, alternating.
4. MAX_BURST=2, all valid, out_ready=1 -> out_sel 0,0,1,1,2,2,3,3,0,0. With only requester 3 valid -> sel 3 on every cycle.
5. Traffic drops to in_valid=0000 after a grant to requester 1, with out_ready=1 -> out_valid=0 the next cycle and out_sel holds 1. When 1111 returns, the first grant is requester 2.
6. Pull rst_n low asynchronously between clock edges while out_valid=1 -> out_valid=0 and in_ready=0000 without waiting for a clock edge. After release with in_valid=1010, the first grant is requester 1 with in_data3='x, and out_data must contain no X.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbiter with optional burst allowance feeding one registered output stage.
// Latency: one cycle from the accepted input to out_valid/out_data/out_sel.
// Backpressure: the output stage loads only when empty or drained (in_ready=0 while out_valid && !out_ready).
module rr_mux_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    logic [1:0]       ptr;
    logic [1:0]       last;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_new;
    logic             load;
    logic             found;
    logic [1:0]       g;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mux_dat;

    assign load = !out_valid || out_ready;

    // First valid requester at or above ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        g     = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign in_ready = (rst_n && load && found) ? (4'b0001 << g) : 4'b0000;

    // Only the granted word reaches the register, so X on other requesters is blocked.
    always_comb begin
        mux_dat = '0;
        case (g)
            2'd0:    mux_dat = in_data0;
            2'd1:    mux_dat = in_data1;
            2'd2:    mux_dat = in_data2;
            default: mux_dat = in_data3;
        endcase
    end

    // Burst count saturates at MAX_BURST; it never exceeds it.
    always_comb begin
        cnt_new = CW'(1);
        if (g == last && cnt != '0) begin
            cnt_new = (cnt == MAXB) ? MAXB : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
            last      <= 2'd0;
            cnt       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= mux_dat;
                out_sel   <= g;
                cnt       <= cnt_new;
                last      <= g;
                ptr       <= (cnt_new < MAXB) ? g : g + 2'd1;
            end else begin
                out_valid <= 1'b0;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: table-driven round-robin sequence with a scoreboard,
// plus hand sequences for burst allowance and asynchronous reset.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic       out_ready;

    logic [3:0] in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [3:0] out_data,  out_data2;
    logic [1:0] out_sel,   out_sel2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_mux_arbiter #(.WIDTH(4), .MAX_BURST(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_sel(out_sel2), .out_ready(out_ready)
    );

    typedef struct {
        logic [3:0]  iv;
        logic        ordy;
        logic [15:0] dat;   // {d3,d2,d1,d0}
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  sel;
        logic [3:0]  od;
    } vec_t;

    vec_t       tbl[25];
    logic [5:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] iv, input logic ordy, input logic [15:0] dat);
        in_valid  = iv;
        out_ready = ordy;
        {in_data3, in_data2, in_data1, in_data0} = dat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'b1111, 1'b1, 16'hDCBA);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        drive(4'b0000, 1'b1, 16'hDCBA);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_sel2[10];
        logic [5:0] popped;
        logic [1:0] gi;

        rst_n = 1'b0;
        drive(4'b0000, 1'b1, 16'h0000);

        tbl[0]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0001, 1'b0, 2'd0, 4'h0};
        tbl[1]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd0, 4'hA};
        tbl[2]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0100, 1'b1, 2'd1, 4'hB};
        tbl[3]  = '{4'hF, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd2, 4'hC};
        tbl[4]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0001, 1'b1, 2'd3, 4'hD};
        tbl[5]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd0, 4'hA};
        tbl[6]  = '{4'hF, 1'b0, 16'hDCBA, 4'b0000, 1'b1, 2'd1, 4'hB};
        tbl[7]  = '{4'hF, 1'b0, 16'hDCBA, 4'b0000, 1'b1, 2'd1, 4'hB};
        tbl[8]  = '{4'hF, 1'b0, 16'hDCBA, 4'b0000, 1'b1, 2'd1, 4'hB};
        tbl[9]  = '{4'hF, 1'b1, 16'hDCBA, 4'b0100, 1'b1, 2'd1, 4'hB};
        tbl[10] = '{4'hF, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd2, 4'hC};
        tbl[11] = '{4'hF, 1'b1, 16'hDCBA, 4'b0001, 1'b1, 2'd3, 4'hD};
        tbl[12] = '{4'hF, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd0, 4'hA};
        tbl[13] = '{4'h0, 1'b1, 16'hDCBA, 4'b0000, 1'b1, 2'd1, 4'hB};
        tbl[14] = '{4'h0, 1'b1, 16'hDCBA, 4'b0000, 1'b0, 2'd1, 4'hB};
        tbl[15] = '{4'hF, 1'b1, 16'hDCBA, 4'b0100, 1'b0, 2'd1, 4'hB};
        tbl[16] = '{4'hF, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd2, 4'hC};
        tbl[17] = '{4'h4, 1'b1, 16'hD7BA, 4'b0100, 1'b1, 2'd3, 4'hD};
        tbl[18] = '{4'h4, 1'b1, 16'hD7BA, 4'b0100, 1'b1, 2'd2, 4'h7};
        tbl[19] = '{4'h4, 1'b1, 16'hD7BA, 4'b0100, 1'b1, 2'd2, 4'h7};
        tbl[20] = '{4'h6, 1'b1, 16'hD73A, 4'b0010, 1'b1, 2'd2, 4'h7};
        tbl[21] = '{4'h6, 1'b1, 16'hD73A, 4'b0100, 1'b1, 2'd1, 4'h3};
        tbl[22] = '{4'h6, 1'b1, 16'hD73A, 4'b0010, 1'b1, 2'd2, 4'h7};
        tbl[23] = '{4'h0, 1'b1, 16'hD73A, 4'b0000, 1'b1, 2'd1, 4'h3};
        tbl[24] = '{4'h0, 1'b1, 16'hD73A, 4'b0000, 1'b0, 2'd1, 4'h3};

        // Round robin, stall, idle gap and single/dual requester traffic.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].dat);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
            if (out_valid && tbl[i].ordy) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: output word %0h with no expected entry at vector %0d", {out_sel, out_data}, i);
                end else begin
                    popped = sb_q.pop_front();
                    chk($sformatf("sb%0d_word", i), 32'({out_sel, out_data}), 32'(popped));
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (tbl[i].rdy[k]) begin
                    gi = 2'(k);
                    sb_q.push_back({gi, tbl[i].dat[k*4 +: 4]});
                end
            end
        end
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);

        // Burst allowance of two, then a lone requester 3.
        exp_sel2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(4'b1111, 1'b1, 16'hDCBA);
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d_valid", i), 32'(out_valid2), 32'd1);
            chk($sformatf("burst%0d_sel", i), 32'(out_sel2), 32'(exp_sel2[i]));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(4'b1000, 1'b1, 16'hDCBA);
            #1;
            chk($sformatf("solo%0d_in_ready", i), 32'(in_ready2), 32'b1000);
            @(posedge clk);
            #1;
            chk($sformatf("solo%0d_sel", i), 32'(out_sel2), 32'd3);
            chk($sformatf("solo%0d_data", i), 32'(out_data2), 32'hD);
        end

        // Asynchronous reset between edges, then X on an unselected requester.
        do_reset();
        @(negedge clk);
        drive(4'b1111, 1'b1, 16'hDCBA);
        @(posedge clk);
        #2;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid  = 4'b1010;
        in_data1  = 4'h5;
        in_data3  = 4'bxxxx;
        rst_n     = 1'b1;
        #1;
        chk("ar_first_grant", 32'(in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("ar_valid", 32'(out_valid), 32'd1);
        chk("ar_sel", 32'(out_sel), 32'd1);
        chk("ar_data", 32'(out_data), 32'h5);
        chk("ar_data_no_x", 32'($isunknown(out_data)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
